// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmp_pkg
//  Description : Shared types and result encoding for serial_word_comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One-hot verdict, ordered {eq, gt, lt}
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic logic [2:0] encode_result(input logic is_eq, input logic is_gt);
        if (is_eq)
            return RES_EQ;
        else if (is_gt)
            return RES_GT;
        else
            return RES_LT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_compare_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bit_compare_cell
//  Description : Single-bit equality / greater-than cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_compare_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic bit_eq,
    output logic bit_gt
);

    assign bit_eq = ~(a_bit ^ b_bit);
    assign bit_gt = a_bit & ~b_bit;

endmodule
`default_nettype wire

// File: rtl/serial_word_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_comparator
//  Description : MSB-first bit-serial unsigned comparator with valid/ready
//                handshakes. Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the
//                walk at the first mismatching bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int                c_idx_w   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_idx_msb = c_idx_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_idx_w-1:0] r_idx;
    logic               r_eq_acc;
    logic               r_gt_acc;
    logic               r_eq;
    logic               r_gt;
    logic               r_lt;

    logic w_load;
    logic w_finish;
    logic w_last_bit;
    logic w_bit_eq;
    logic w_bit_gt;
    logic w_eq_next;
    logic w_gt_next;

    bit_compare_cell u_bit_cell (
        .a_bit  (r_a[r_idx]),
        .b_bit  (r_b[r_idx]),
        .bit_eq (w_bit_eq),
        .bit_gt (w_bit_gt)
    );

    // Direction is captured only on the first mismatch and held afterwards
    assign w_eq_next = r_eq_acc & w_bit_eq;
    assign w_gt_next = r_eq_acc ? w_bit_gt : r_gt_acc;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign w_last_bit = (r_idx == '0) || (r_eq_acc && !w_bit_eq);
`else
    assign w_last_bit = (r_idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = SHIFT;
                    w_load       = 1'b1;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_state_next = DONE;
                    w_finish     = 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_eq_acc <= 1'b0;
            r_gt_acc <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            if (w_load) begin
                r_a      <= a;
                r_b      <= b;
                r_idx    <= c_idx_msb;
                r_eq_acc <= 1'b1;
                r_gt_acc <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_eq_acc <= w_eq_next;
                r_gt_acc <= w_gt_next;
                if (r_idx != '0)
                    r_idx <= r_idx - c_idx_w'(1);
            end
            // Verdict registers change only on entry to DONE
            if (w_finish)
                {r_eq, r_gt, r_lt} <= encode_result(w_eq_next, w_gt_next);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign lt        = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_comparator
//  Description : Self-checking bench for serial_word_comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_comparator;

    localparam int WIDTH = 8;
    localparam logic [2:0] E_EQ = 3'b100;  // {eq, gt, lt}
    localparam logic [2:0] E_GT = 3'b010;
    localparam logic [2:0] E_LT = 3'b001;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             busy;

    serial_word_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       res;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    exp_t       sb[$];
    int         acc_q[$];
    logic [2:0] last_res = 3'b000;
    logic       prev_ov  = 1'b0;
    logic       post_hs  = 1'b0;
    logic       b2b_mode = 1'b0;
    int         last_acc = -1;
    vec_t       vecs[9];
    vec_t       b2b[4];
    logic [WIDTH-1:0] rst_a;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int p = WIDTH - 1; p >= 0; p--)
            if (x[p] != y[p])
                return WIDTH - p;
`endif
        return WIDTH;
    endfunction

    // Monitor: accept timestamps, latency, verdict, hold behaviour
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            post_hs = 1'b0;
        end else begin
            check("busy_vs_ready", 32'(busy), 32'(!in_ready));
            if (in_valid && in_ready) begin
                if (b2b_mode && last_acc >= 0)
                    check("b2b_spacing", 32'(cyc + 1 - last_acc), 32'(WIDTH + 2));
                last_acc = cyc + 1;
                acc_q.push_back(cyc + 1);
            end
            if (post_hs) begin
                check("ov_one_cycle", 32'(out_valid), 32'd0);
                check("ready_after_done", 32'(in_ready), 32'd1);
                post_hs = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(sb.size()), 32'd1);
                end else begin
                    if (!prev_ov) begin
                        check("accept_seen", 32'(acc_q.size() > 0), 32'd1);
                        if (acc_q.size() > 0) begin
                            check("latency", 32'(cyc - acc_q[0]), 32'(sb[0].lat));
                            void'(acc_q.pop_front());
                        end
                    end
                    check("result", 32'({eq, gt, lt}), 32'(sb[0].res));
                    check("onehot", 32'($onehot({eq, gt, lt})), 32'd1);
                    if (out_ready) begin
                        last_res = sb[0].res;
                        void'(sb.pop_front());
                        post_hs = 1'b1;
                    end
                end
            end else begin
                check("hold_last", 32'({eq, gt, lt}), 32'(last_res));
            end
            prev_ov = out_valid;
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] res);
        exp_t e;
        e.res = res;
        e.lat = model_lat(x, y);
        sb.push_back(e);
    endtask

    // Returns at #1 after the accepting edge
    task automatic wait_accept();
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] res);
        @(posedge clk);
        #1;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        push_exp(x, y, res);
        wait_accept();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h5A, E_EQ};
        vecs[1] = '{8'h80, 8'h7F, E_GT};
        vecs[2] = '{8'h01, 8'h02, E_LT};
        vecs[3] = '{8'hFF, 8'hFE, E_GT};
        vecs[4] = '{8'h00, 8'h00, E_EQ};
        vecs[5] = '{8'h00, 8'hFF, E_LT};
        vecs[6] = '{8'h7F, 8'h80, E_LT};
        vecs[7] = '{8'hC3, 8'hC2, E_GT};
        vecs[8] = '{8'hFF, 8'hFF, E_EQ};
        b2b[0]  = '{8'h11, 8'h11, E_EQ};
        b2b[1]  = '{8'h10, 8'h11, E_LT};
        b2b[2]  = '{8'h33, 8'h32, E_GT};
        b2b[3]  = '{8'hAA, 8'hAA, E_EQ};
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        rst_a = 8'h01;
`else
        rst_a = 8'hFF;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'({eq, gt, lt}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_pair(vecs[i].a, vecs[i].b, vecs[i].res);

        // Consumer stalls for 5 cycles while a new pair waits
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a        = 8'h10;
        b        = 8'h20;
        in_valid = 1'b1;
        push_exp(8'h10, 8'h20, E_LT);
        wait_accept();
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("held_reached_done", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("held_out_valid", 32'(out_valid), 32'd1);
            check("held_in_ready", 32'(in_ready), 32'd0);
            check("held_lt", 32'(lt), 32'd1);
        end
        push_exp(8'h10, 8'h20, E_LT);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        wait_drain();

        // Reset during the 4th SHIFT cycle aborts the operation
        @(posedge clk);
        #1;
        a        = rst_a;
        b        = 8'h00;
        in_valid = 1'b1;
        push_exp(rst_a, 8'h00, E_GT);
        wait_accept();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        sb.delete();
        acc_q.delete();
        last_res = 3'b000;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'({eq, gt, lt}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            check("no_result_after_abort", 32'(out_valid), 32'd0);
        end
        run_pair(8'h03, 8'h03, E_EQ);

        // Back-to-back accepts with in_valid held high
        b2b_mode = 1'b1;
        last_acc = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = b2b[i].a;
            b = b2b[i].b;
            push_exp(b2b[i].a, b2b[i].b, b2b[i].res);
            wait_accept();
        end
        in_valid = 1'b0;
        wait_drain();
        b2b_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
